// File: rtl/conv_operand_loader.sv
// Serial operand loader for the convolution stage: collects an NxN pixel block and
// kernel onto a fixed 5x5 byte grid, then registers the convolution stage's result.
module conv_operand_loader (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         matrix_size,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic [199:0]       matrix_a,
   output logic [199:0]       matrix_b,
   output logic [1:0]         size_out,
   input  logic signed [15:0] conv_result,
   output logic signed [15:0] result_out,
   output logic               done,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_SETTLE, S_CAPTURE
   } state_t;

   state_t             r_state;
   logic [2:0]         r_row;
   logic [2:0]         r_col;
   logic [1:0]         r_size;
   logic [199:0]       r_a;
   logic [199:0]       r_b;
   logic signed [15:0] r_res;
   logic               r_done;

   logic [2:0] w_nm1;
   logic [4:0] w_idx;
   logic [7:0] w_bit;
   logic       w_last_col;
   logic       w_last_row;

   // N-1 = size+1; elements always land on the 5-wide grid regardless of N
   assign w_nm1      = {1'b0, r_size} + 3'd1;
   assign w_idx      = {r_row, 2'b00} + {2'b00, r_row} + {2'b00, r_col};
   assign w_bit      = {w_idx, 3'b000};
   assign w_last_col = (r_col == w_nm1);
   assign w_last_row = (r_row == w_nm1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_size  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_size  <= matrix_size;
                  r_a     <= '0;
                  r_b     <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_state <= S_LOAD_A;
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (byte_valid) begin
                  if (r_state == S_LOAD_A) r_a[w_bit +: 8] <= byte_in;
                  else                     r_b[w_bit +: 8] <= byte_in;
                  if (w_last_col) begin
                     r_col <= '0;
                     if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= (r_state == S_LOAD_A) ? S_LOAD_B : S_SETTLE;
                     end else begin
                        r_row <= r_row + 3'd1;
                     end
                  end else begin
                     r_col <= r_col + 3'd1;
                  end
               end
            end
            // one cycle for the downstream combinational result to settle
            S_SETTLE: r_state <= S_CAPTURE;
            S_CAPTURE: begin
               r_res   <= conv_result;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign byte_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign busy       = (r_state != S_IDLE);
   assign matrix_a   = r_a;
   assign matrix_b   = r_b;
   assign size_out   = r_size;
   assign result_out = r_res;
   assign done       = r_done;

endmodule

// File: tb/tb_conv_operand_loader.sv
// Scoreboard bench for conv_operand_loader; also stands in for the convolution stage.
module tb_conv_operand_loader;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [1:0]         matrix_size;
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic [199:0]       matrix_a;
   logic [199:0]       matrix_b;
   logic [1:0]         size_out;
   logic signed [15:0] conv_result;
   logic signed [15:0] result_out;
   logic               done;
   logic               busy;

   typedef struct {
      logic [1:0]         size;
      logic [199:0]       a;
      logic [199:0]       b;
      logic signed [15:0] res;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   xfer_cnt = 0;
   logic [7:0] pix[25];
   logic [7:0] ker[25];

   conv_operand_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .matrix_a(matrix_a), .matrix_b(matrix_b), .size_out(size_out),
      .conv_result(conv_result), .result_out(result_out), .done(done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // correlation of unsigned pixels with signed kernel, saturated to 16 bits
   function automatic logic signed [15:0] conv_fn(input logic [199:0] a, input logic [199:0] b);
      int s;
      s = 0;
      for (int k = 0; k < 25; k++)
         s += int'(a[8*k +: 8]) * int'($signed(b[8*k +: 8]));
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   assign conv_result = conv_fn(matrix_a, matrix_b);

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (byte_valid && byte_ready) xfer_cnt++;
   end

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input int sz, input bit throttle, input bit hold_start);
      int   n, c, xb, db;
      exp_t e;
      n = sz + 2;
      e.size = sz[1:0];
      e.a = '0;
      e.b = '0;
      for (int i = 0; i < n*n; i++) begin
         e.a[8*((i/n)*5 + i%n) +: 8] = pix[i];
         e.b[8*((i/n)*5 + i%n) +: 8] = ker[i];
      end
      e.res = conv_fn(e.a, e.b);
      sb_q.push_back(e);
      xb = xfer_cnt;
      db = done_cnt;
      start = 1'b1;
      matrix_size = sz[1:0];
      @(posedge clk) #1;
      chk("busy_after_start", busy, 1);
      if (hold_start) matrix_size = ~sz[1:0];
      else            start = 1'b0;
      for (int i = 0; i < 2*n*n; i++) begin
         if (throttle) begin
            byte_valid = 1'b0;
            @(posedge clk) #1;
         end
         byte_valid = 1'b1;
         byte_in = (i < n*n) ? pix[i] : ker[i - n*n];
         @(posedge clk) #1;
      end
      byte_valid = 1'b0;
      c = 0;
      while (!done && c < 8) begin
         @(posedge clk) #1;
         c++;
      end
      start = 1'b0;
      chk("done_latency", c, 2);
      chk("xfers", xfer_cnt - xb, 2*n*n);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk("result_out", result_out, e.res);
         chk("matrix_a", matrix_a, e.a);
         chk("matrix_b", matrix_b, e.b);
         chk("size_out", size_out, e.size);
         repeat (3) @(posedge clk);
         #1;
         chk("done_once", done_cnt - db, 1);
         chk("idle_busy", busy, 0);
         chk("hold_a", matrix_a, e.a);
         chk("hold_res", result_out, e.res);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; matrix_size = '0; byte_in = '0; byte_valid = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_ready", byte_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_a", matrix_a, 0);
      chk("rst_res", result_out, 0);
      rst_n = 1'b1;
      @(posedge clk) #1;

      // 2x2 reference case
      pix[0] = 8'd10; pix[1] = 8'd20; pix[2] = 8'd30; pix[3] = 8'd40;
      ker[0] = 8'd1;  ker[1] = 8'hFF; ker[2] = 8'd2;  ker[3] = 8'hFE;
      do_load(0, 0, 0);

      // 5x5 saturating case
      for (int i = 0; i < 25; i++) begin pix[i] = 8'd255; ker[i] = 8'd127; end
      do_load(3, 0, 0);
      chk("sat_result", result_out, 16'sd32767);

      // 3x3 throttled stream
      for (int i = 0; i < 25; i++) begin pix[i] = 8'(i*3 + 1); ker[i] = 8'(i - 4); end
      do_load(1, 1, 0);

      // 4x4 with start and a different size held high during the load
      for (int i = 0; i < 25; i++) begin pix[i] = 8'($urandom); ker[i] = 8'($urandom); end
      do_load(2, 0, 1);

      // reset mid-load after 7 pixel bytes of a 3x3
      start = 1'b1; matrix_size = 2'b01;
      @(posedge clk) #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         byte_valid = 1'b1; byte_in = 8'(i + 100);
         @(posedge clk) #1;
      end
      byte_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", byte_ready, 0);
      chk("mid_rst_a", matrix_a, 0);
      chk("mid_rst_size", size_out, 0);
      chk("mid_rst_res", result_out, 0);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", busy, 0);
      for (int i = 0; i < 25; i++) begin pix[i] = 8'($urandom); ker[i] = 8'($urandom); end
      do_load(0, 0, 0);

      // back-to-back 5x5 then 2x2: no residue
      for (int i = 0; i < 25; i++) begin pix[i] = 8'($urandom_range(1, 255)); ker[i] = 8'($urandom); end
      do_load(3, 0, 0);
      for (int i = 0; i < 25; i++) begin pix[i] = 8'(i + 7); ker[i] = 8'(i + 1); end
      do_load(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
